// File: rtl/reg_file_pkg.sv
// Shared sizing, address/data types and writeback bus struct for the
// integer register file and its pending-write scoreboard.
package reg_file_pkg;
  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NRD        = 2;

  typedef logic [REG_ADDR_W-1:0] raddr_t;
  typedef logic [XLEN-1:0]       xdata_t;

  localparam raddr_t ZERO_REG = 5'd0;

  typedef struct packed {
    logic   vld;
    raddr_t rd;
    xdata_t data;
  } wb_req_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits: issue sets, flush or writeback clears,
// busy lookup for both ID read ports with writeback-cycle masking.
module reg_scoreboard
  import reg_file_pkg::*;
(
  input  logic               clk,
  input  logic               rst_i,
  input  logic               issue_i,
  input  raddr_t             issue_rd_i,
  input  logic               flush_i,
  input  wb_req_t            wb_i,
  input  raddr_t [NRD-1:0]   rs_addr_i,
  output logic   [NRD-1:0]   rs_busy_o
);
  logic [NREG-1:0] pend_q, pend_d;

  // Issue beats flush and writeback so a re-issued destination stays marked.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREG; r++) begin
      if (issue_i && issue_rd_i == raddr_t'(r))        pend_d[r] = 1'b1;
      else if (flush_i)                                pend_d[r] = 1'b0;
      else if (wb_i.vld && wb_i.rd == raddr_t'(r))     pend_d[r] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_busy
    assign rs_busy_o[p] = rst_i && pend_q[rs_addr_i[p]] &&
                          !(wb_i.vld && wb_i.rd == rs_addr_i[p]);
  end
endmodule

// File: rtl/reg_file.sv
// 32x32 architectural register file: two combinational read ports with
// same-cycle writeback bypass, one synchronous write port, pending scoreboard.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              rst_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic [4:0]        rd_addr_i,
  input  logic [XLEN-1:0]   reg_write_data_i,
  input  logic              reg_write_i,
  input  logic              issue_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              flush_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o
);
  logic [NREG-1:0][XLEN-1:0] regs_q;
  wb_req_t                   wb;
  raddr_t  [NRD-1:0]         rs_addr;
  xdata_t  [NRD-1:0]         rs_data;
  logic    [NRD-1:0]         rs_busy;

  assign wb.vld  = reg_write_i;
  assign wb.rd   = rd_addr_i;
  assign wb.data = reg_write_data_i;

  assign rs_addr    = {rs2_addr_i, rs1_addr_i};
  assign rs1_data_o = rs_data[0];
  assign rs2_data_o = rs_data[1];
  assign rs1_busy_o = rs_busy[0];
  assign rs2_busy_o = rs_busy[1];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) regs_q <= '0;
    else if (wb.vld && wb.rd != ZERO_REG) regs_q[wb.rd] <= wb.data;
  end

  // Bypass is gated by reset so outputs read zero while rst_i is low.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    always_comb begin
      rs_data[p] = regs_q[rs_addr[p]];
      if (rs_addr[p] == ZERO_REG || !rst_i)
        rs_data[p] = '0;
      else if (wb.vld && wb.rd == rs_addr[p])
        rs_data[p] = wb.data;
    end
  end

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_i      (rst_i),
    .issue_i    (issue_i),
    .issue_rd_i (issue_rd_i),
    .flush_i    (flush_i),
    .wb_i       (wb),
    .rs_addr_i  (rs_addr),
    .rs_busy_o  (rs_busy)
  );
endmodule
